// File: rtl/gauss_out_crop_if.sv
// Pixel stream bundle between the filter core read side, the crop stage and the frame writer.
// The master drives the input beat; the slave returns the cropped, framed pixel.
interface gauss_out_crop_if #(
    parameter int DW = 15
);
    logic          rdreq;
    logic          frame_sync;
    logic          bypass;
    logic [DW-1:0] out;
    logic [DW-1:0] true_out;
    logic          out_valid;
    logic          out_sol;
    logic          out_eol;
    logic          out_sof;
    logic          out_eof;

    modport master (
        output rdreq, frame_sync, bypass, out,
        input  true_out, out_valid, out_sol, out_eol, out_sof, out_eof
    );

    modport slave (
        input  rdreq, frame_sync, bypass, out,
        output true_out, out_valid, out_sol, out_eol, out_sof, out_eof
    );
endinterface

// File: rtl/gauss_out_crop.sv
// Gaussian filter output stage: tracks column/row of each input beat, drops the border
// window, tags kept pixels with line/frame flags and delays them by PIPE register stages.
module gauss_out_crop #(
    parameter int DW      = 15,
    parameter int LINE_W  = 300,
    parameter int FRAME_H = 300,
    parameter int CROP_L  = 1,
    parameter int CROP_R  = 1,
    parameter int CROP_T  = 1,
    parameter int CROP_B  = 1,
    parameter int PIPE    = 2
) (
    input logic            clk,
    input logic            rst,
    gauss_out_crop_if.slave bus
);
    localparam int CW = $clog2(LINE_W);
    localparam int RW = $clog2(FRAME_H);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          valid;
        logic          sol;
        logic          eol;
        logic          sof;
        logic          eof;
    } stage_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    stage_t        head;
    stage_t        pipe [PIPE];

    // A beat arriving together with frame_sync is the first pixel of the new frame.
    assign cur_col = bus.frame_sync ? '0 : col;
    assign cur_row = bus.frame_sync ? '0 : row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.frame_sync) begin
            col <= bus.rdreq ? CW'(1) : '0;
            row <= '0;
        end else if (bus.rdreq) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Window bounds collapse to the full frame in bypass; comparisons are done as signed ints.
    always_comb begin
        int c, r, wl, wr, wt, wb;
        logic keep;
        c    = int'(cur_col);
        r    = int'(cur_row);
        wl   = bus.bypass ? 0           : CROP_L;
        wr   = bus.bypass ? LINE_W - 1  : LINE_W - 1 - CROP_R;
        wt   = bus.bypass ? 0           : CROP_T;
        wb   = bus.bypass ? FRAME_H - 1 : FRAME_H - 1 - CROP_B;
        keep = bus.rdreq && (c >= wl) && (c <= wr) && (r >= wt) && (r <= wb);
        head       = '0;
        head.data  = keep ? bus.out : '0;
        head.valid = keep;
        head.sol   = keep && (c == wl);
        head.eol   = keep && (c == wr);
        head.sof   = keep && (c == wl) && (r == wt);
        head.eof   = keep && (c == wr) && (r == wb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= head;
            for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.true_out  = pipe[PIPE-1].data;
    assign bus.out_valid = pipe[PIPE-1].valid;
    assign bus.out_sol   = pipe[PIPE-1].sol;
    assign bus.out_eol   = pipe[PIPE-1].eol;
    assign bus.out_sof   = pipe[PIPE-1].sof;
    assign bus.out_eof   = pipe[PIPE-1].eof;
endmodule

// File: tb/tb_gauss_out_crop.sv
// Directed bench for gauss_out_crop on an 8x4 frame with a one-pixel border and two-stage latency.
// Expected outputs are queued per beat and compared PIPE cycles later at the falling edge.
module tb_gauss_out_crop;
    localparam int PIPE = 2;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    logic [12:0] expq [$];

    gauss_out_crop_if #(.DW(8)) bus ();

    gauss_out_crop #(
        .DW(8), .LINE_W(8), .FRAME_H(4),
        .CROP_L(1), .CROP_R(1), .CROP_T(1), .CROP_B(1),
        .PIPE(PIPE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Kept pixels of an 8x4 frame with a one-pixel border: indices 9..14 and 17..22.
    function automatic logic [12:0] expCrop(input int idx, input logic [7:0] d);
        logic v, sol, eol, sof, eof;
        v   = (idx >= 9 && idx <= 14) || (idx >= 17 && idx <= 22);
        sol = (idx == 9)  || (idx == 17);
        eol = (idx == 14) || (idx == 22);
        sof = (idx == 9);
        eof = (idx == 22);
        return {v ? d : 8'h00, v, sol, eol, sof, eof};
    endfunction

    function automatic logic [12:0] expBypass(input int idx, input logic [7:0] d);
        return {d, 1'b1, (idx % 8) == 0, (idx % 8) == 7, idx == 0, idx == 31};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.out_valid ? bus.true_out : 8'h00, bus.out_valid,
                bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof};
    endfunction

    task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] expected);
        checkCount++;
        assert (obs === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h (data,valid,sol,eol,sof,eof)",
                   tag, obs, expected);
        end
    endtask

    task automatic primeQueue();
        expq.delete();
        repeat (PIPE) expq.push_back(13'h0);
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic s, input logic b,
                                 input logic [7:0] d, input logic [12:0] expected);
        @(negedge clk);
        checkOutput(tag, observed(), expq.pop_front());
        bus.rdreq      = r;
        bus.frame_sync = s;
        bus.bypass     = b;
        bus.out        = d;
        expq.push_back(expected);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus("idle", 1'b0, 1'b0, 1'b0, 8'h00, 13'h0);
    endtask

    initial begin
        bus.rdreq = 1'b0;
        bus.frame_sync = 1'b0;
        bus.bypass = 1'b0;
        bus.out = 8'h00;
        rst = 1'b1;
        primeQueue();
        #12;
        checkOutput("reset_state", {bus.true_out, bus.out_valid, bus.out_sol,
                    bus.out_eol, bus.out_sof, bus.out_eof}, 13'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++)
            applyStimulus("crop_frame", 1'b1, 1'b0, 1'b0, 8'(i), expCrop(i, 8'(i)));
        idle(3);

        // Every other clock idle: kept sequence and flags must match the contiguous frame.
        for (int i = 0; i < 32; i++) begin
            applyStimulus("gap_beat", 1'b1, 1'b0, 1'b0, 8'(i), expCrop(i, 8'(i)));
            applyStimulus("gap_idle", 1'b0, 1'b0, 1'b0, 8'hAA, 13'h0);
        end
        idle(3);

        for (int i = 0; i < 32; i++)
            applyStimulus("bypass_frame", 1'b1, 1'b0, 1'b1, 8'(i), expBypass(i, 8'(i)));
        idle(3);

        for (int i = 0; i < 12; i++)
            applyStimulus("pre_sync", 1'b1, 1'b0, 1'b0, 8'(i), expCrop(i, 8'(i)));
        applyStimulus("sync_beat", 1'b1, 1'b1, 1'b0, 8'd12, 13'h0);
        for (int j = 0; j < 32; j++)
            applyStimulus("post_sync", 1'b1, 1'b0, 1'b0, 8'(100 + j),
                          expCrop((j + 1) % 32, 8'(100 + j)));
        idle(3);

        // Realign with frame_sync, then reset while pixels 9 and 10 sit in the pipeline.
        applyStimulus("rst_frame", 1'b1, 1'b1, 1'b0, 8'd0, expCrop(0, 8'd0));
        for (int i = 1; i <= 10; i++)
            applyStimulus("rst_frame", 1'b1, 1'b0, 1'b0, 8'(i), expCrop(i, 8'(i)));
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rdreq = 1'b0;
        #1;
        checkOutput("rst_async", {bus.true_out, bus.out_valid, bus.out_sol,
                    bus.out_eol, bus.out_sof, bus.out_eof}, 13'h0);
        primeQueue();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 32; i++)
                applyStimulus("after_rst", 1'b1, 1'b0, 1'b0, 8'(f * 32 + i),
                              expCrop(i, 8'(f * 32 + i)));
        idle(3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
